// File: rtl/alu_multiciclo.sv
// Purpose : registered execute-stage ALU with AND/OR/ADD/SUB/SLTU/NOR/SLL/SRL in one cycle,
//           plus iterative unsigned MUL (shift-add), DIVU and REMU (restoring division).
// Latency : single-cycle ops -> done the cycle after the accepting edge; MUL/DIVU/REMU -> WIDTH cycles.
// Backpr. : start is sampled only while busy=0; a start during busy is dropped, never queued.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, op           request strobe and 4-bit operation code (latched on acceptance)
//   data1, data2        unsigned operands A and B (shift amount is data2[SHW-1:0])
//   busy                iterative operation in progress
//   done                one-cycle pulse: dataOut/zero were just written
//   dataOut, zero       result register and its registered zero flag
//   divByZero           last DIVU/REMU had data2 == 0; cleared by the next accepted start
module alu_multiciclo #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut,
    output logic             zero,
    output logic             divByZero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        K_MUL,
        K_DIV,
        K_REM
    } kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // x: MUL multiplicand (shifts left) / DIV dividend shifting out, quotient shifting in
    // y: MUL multiplier (shifts right)  / DIV divisor (constant)
    // acc: MUL partial product          / DIV partial remainder
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_acc_nx;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quot_nx;
    logic [WIDTH-1:0] iter_res;

    // Single-cycle results straight from the inputs at the accepting edge.
    always_comb begin
        alu_res = '0;
        shamt   = data2[SHW-1:0];
        case (op)
            OP_AND:  alu_res = data1 & data2;
            OP_OR:   alu_res = data1 | data2;
            OP_ADD:  alu_res = data1 + data2;
            OP_SUB:  alu_res = data1 - data2;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
            OP_NOR:  alu_res = ~(data1 | data2);
            OP_SLL:  alu_res = data1 << shamt;
            OP_SRL:  alu_res = data1 >> shamt;
            default: alu_res = '0;
        endcase
    end

    // One iteration step of each iterative algorithm, from the current registers.
    // With a zero divisor every trial subtract succeeds, so the quotient fills with
    // ones and the remainder ends up equal to the dividend without special casing.
    always_comb begin
        mul_acc_nx = y_q[0] ? (acc_q + x_q) : acc_q;
        div_trial  = {acc_q, x_q[WIDTH-1]};
        div_ge     = (div_trial >= {1'b0, y_q});
        div_diff   = div_ge ? (div_trial - {1'b0, y_q}) : div_trial;
        rem_nx     = div_diff[WIDTH-1:0];
        quot_nx    = {x_q[WIDTH-2:0], div_ge};
        case (kind_q)
            K_MUL:   iter_res = mul_acc_nx;
            K_DIV:   iter_res = quot_nx;
            default: iter_res = rem_nx;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        acc_d      = acc_q;
        data_out_d = data_out_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dbz_d = 1'b0;
                    x_d   = data1;
                    y_d   = data2;
                    acc_d = '0;
                    cnt_d = CNT_INIT;
                    case (op)
                        OP_MUL: begin
                            state_d = RUN;
                            kind_d  = K_MUL;
                        end
                        OP_DIVU: begin
                            state_d = RUN;
                            kind_d  = K_DIV;
                        end
                        OP_REMU: begin
                            state_d = RUN;
                            kind_d  = K_REM;
                        end
                        default: begin
                            data_out_d = alu_res;
                            zero_d     = (alu_res == '0);
                            done_d     = 1'b1;
                        end
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_LAST;
                if (kind_q == K_MUL) begin
                    acc_d = mul_acc_nx;
                    x_d   = x_q << 1;
                    y_d   = y_q >> 1;
                end else begin
                    acc_d = rem_nx;
                    x_d   = quot_nx;
                end
                // The final iteration's result is written on the same edge.
                if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    data_out_d = iter_res;
                    zero_d     = (iter_res == '0);
                    if (kind_q != K_MUL) begin
                        dbz_d = (y_q == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            kind_q     <= K_MUL;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
            zero_q     <= 1'b1;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign dataOut   = data_out_q;
    assign zero      = zero_q;
    assign divByZero = dbz_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo: a 32-bit instance for the main vectors and an
// 8-bit instance for the narrow-width build. Inputs change and outputs are sampled
// on the falling edge, away from the active rising edge.
module tb_alu_multiciclo;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;

    logic        start;
    logic [3:0]  op;
    logic [31:0] data1, data2;
    logic        busy, done, zero, dbz;
    logic [31:0] dataOut;

    logic        start8;
    logic [3:0]  op8;
    logic [7:0]  d1_8, d2_8;
    logic        busy8, done8, zero8, dbz8;
    logic [7:0]  out8;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    alu_multiciclo #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .data1     (data1),
        .data2     (data2),
        .busy      (busy),
        .done      (done),
        .dataOut   (dataOut),
        .zero      (zero),
        .divByZero (dbz)
    );

    alu_multiciclo #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start8),
        .op        (op8),
        .data1     (d1_8),
        .data2     (d2_8),
        .busy      (busy8),
        .done      (done8),
        .dataOut   (out8),
        .zero      (zero8),
        .divByZero (dbz8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; issues one single-cycle op and checks the done pulse.
    task automatic run_single(input string tag, input logic [3:0] o,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
        op = o; data1 = a; data2 = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check1({tag, " done"}, done, 1'b1);
        check ({tag, " dataOut"}, dataOut, exp);
        check1({tag, " zero"}, zero, (exp == 32'h0));
        check1({tag, " busy"}, busy, 1'b0);
        check1({tag, " dbz"}, dbz, 1'b0);
        @(negedge clk);
        check1({tag, " done low"}, done, 1'b0);
        check ({tag, " hold"}, dataOut, exp);
    endtask

    // Called at a falling edge; returns at the falling edge where done is seen,
    // so a following call issues its start in the done cycle.
    task automatic run_iter(input string tag, input logic [3:0] o,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input logic exp_dbz,
                            input bit toggle);
        int cyc;
        int busy_n;
        op = o; data1 = a; data2 = b; start = 1'b1;
        @(posedge clk);
        cyc = 0;
        busy_n = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (done) break;
            if (cyc == 0) check1({tag, " dbz cleared"}, dbz, 1'b0);
            cyc++;
            if (busy) busy_n++;
            if (toggle) begin
                start = 1'b1;
                op    = 4'($urandom_range(0, 15));
                data1 = $urandom;
                data2 = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check ({tag, " latency"}, cyc, 32);
        check ({tag, " busy cycles"}, busy_n, 32);
        check1({tag, " busy at done"}, busy, 1'b0);
        check ({tag, " dataOut"}, dataOut, exp);
        check1({tag, " zero"}, zero, (exp == 32'h0));
        check1({tag, " dbz"}, dbz, exp_dbz);
    endtask

    task automatic run_iter8(input string tag, input logic [3:0] o,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] exp);
        int cyc;
        op8 = o; d1_8 = a; d2_8 = b; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        check ({tag, " latency"}, cyc, 8);
        check ({tag, " dataOut"}, 32'(out8), 32'(exp));
        check1({tag, " busy at done"}, busy8, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pulses;
        start = 1'b0; op = '0; data1 = '0; data2 = '0;
        start8 = 1'b0; op8 = '0; d1_8 = '0; d2_8 = '0;

        // Reset state
        #2 reset = 1'b1;
        #1;
        check ("rst dataOut", dataOut, 32'h0);
        check1("rst zero", zero, 1'b1);
        check1("rst busy", busy, 1'b0);
        check1("rst done", done, 1'b0);
        check1("rst dbz", dbz, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single-cycle ops
        run_single("add wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        run_single("sub eq",   4'b0110, 32'd5, 32'd5, 32'h0);
        run_single("sltu lt",  4'b0111, 32'd3, 32'hFFFF_FFFF, 32'h1);
        run_single("sltu ge",  4'b0111, 32'hFFFF_FFFF, 32'd3, 32'h0);
        // F0F0F0F0 | 0F0F0F00 = FFFFFFF0, inverted = 0000000F
        run_single("nor",      4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_000F);
        run_single("and",      4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
        run_single("or",       4'b0001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
        run_single("unlisted", 4'b0101, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0);
        // Only data2[4:0] = 15 is used as the shift amount
        run_single("srl mask", 4'b0100, 32'h8000_0000, 32'h0000_002F, 32'h0001_0000);

        // Multiply with start and operands toggled while busy
        run_iter("mul", 4'b1000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, 1'b1);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("mul extra done", pulses, 0);
        check("mul hold", dataOut, 32'h000B_000F);

        // Division; REMU is issued in the DIVU done cycle
        run_iter("divu", 4'b1001, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        run_iter("remu", 4'b1010, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
        run_iter("div0", 4'b1001, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_iter("rem0", 4'b1010, 32'd9, 32'd0, 32'd9, 1'b1, 1'b0);
        run_single("add clr dbz", 4'b0010, 32'd1, 32'd1, 32'd2);

        // Reset in the middle of a multiply
        op = 4'b1000; data1 = 32'd3; data2 = 32'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check1("pre-abort busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check1("abort busy", busy, 1'b0);
        check ("abort dataOut", dataOut, 32'h0);
        check1("abort zero", zero, 1'b1);
        check1("abort done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort no done", pulses, 0);
        run_single("sll 31", 4'b0011, 32'd1, 32'd31, 32'h8000_0000);

        // 8-bit build
        run_iter8("w8 mul", 4'b1000, 8'h10, 8'h11, 8'h10);
        run_iter8("w8 divu", 4'b1001, 8'd200, 8'd3, 8'd66);
        @(negedge clk);
        op8 = 4'b0100; d1_8 = 8'h80; d2_8 = 8'h0B; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        check1("w8 srl done", done8, 1'b1);
        check ("w8 srl dataOut", 32'(out8), 32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
